// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU control codes, RV32I opcode constants and the issue-entry record
// exchanged between the decoder and the issue skid buffer.
package alu_issue_stage_pkg;

  localparam int XLEN_C = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [3:0]        alu_control;
    logic [XLEN_C-1:0] left;
    logic [XLEN_C-1:0] right;
    logic [4:0]        rd;
    logic              reg_write;
    logic              illegal;
  } issue_entry_t;

  // alt selects SUB (funct3 000) or SRA (funct3 101); callers mask it where it must not apply
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] code;
    case (funct3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I integer decoder: instruction, pc and register operands to
// one issue entry. FORWARD_EN adds a single bypass port applied to used sources.
module alu_decoder
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef FORWARD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output issue_entry_t    entry
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [XLEN-1:0] src1_s;
  logic [XLEN-1:0] src2_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_u_s;
  logic            legal_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u_s  = {instr[31:12], 12'b0};

  // source selection; forwarding only where the opcode actually reads that source
  always_comb begin
    src1_s = rs1_data;
    src2_s = rs2_data;
`ifdef FORWARD_EN
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[19:15]) &&
        ((opcode_s == OPC_OP) || (opcode_s == OPC_OP_IMM))) begin
      src1_s = fwd_data;
    end else begin
      src1_s = rs1_data;
    end
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[24:20]) && (opcode_s == OPC_OP)) begin
      src2_s = fwd_data;
    end else begin
      src2_s = rs2_data;
    end
`endif
  end

  // opcode decode; shifts carry only the 5-bit amount since the ALU shifts by the full value
  always_comb begin
    entry   = '0;
    legal_s = 1'b1;
    case (opcode_s)
      OPC_OP: begin
        entry.alu_control = alu_from_funct3(funct3_s, instr[30]);
        entry.left        = src1_s;
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          entry.right = {27'b0, src2_s[4:0]};
        end else begin
          entry.right = src2_s;
        end
      end
      OPC_OP_IMM: begin
        entry.alu_control = alu_from_funct3(funct3_s, (funct3_s == 3'b101) && instr[30]);
        entry.left        = src1_s;
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          entry.right = {27'b0, instr[24:20]};
        end else begin
          entry.right = imm_i_s;
        end
      end
      OPC_LUI: begin
        entry.alu_control = ALU_ADD;
        entry.left        = '0;
        entry.right       = imm_u_s;
      end
      OPC_AUIPC: begin
        entry.alu_control = ALU_ADD;
        entry.left        = pc;
        entry.right       = imm_u_s;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
    entry.rd        = legal_s ? instr[11:7] : 5'd0;
    entry.reg_write = legal_s && (instr[11:7] != 5'd0);
    entry.illegal   = !legal_s;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes into a 2-entry skid buffer with registered in_ready/out_valid.
// Optional operand bypass is built in when FORWARD_EN is defined.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef FORWARD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] left_operand,
  output logic [XLEN-1:0] right_operand,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  skid_state_e  state_q, state_d;
  issue_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
  issue_entry_t dec_s;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         push_s, pop_s;

  alu_decoder #(.XLEN(XLEN)) u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
`ifdef FORWARD_EN
    .fwd_valid(fwd_valid),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data),
`endif
    .entry    (dec_s)
  );

  // an accepted illegal op is simply swallowed when it may not issue
  assign push_s = in_valid && in_ready_q && (ILLEGAL_AS_NOP || !dec_s.illegal);
  assign pop_s  = out_valid_q && out_ready;

  // state register; reset dominates flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // occupancy transitions
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = push_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (push_s && !pop_s) begin
            state_d = ST_TWO;
          end else if (!push_s && pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO:   state_d = pop_s ? ST_ONE : ST_TWO;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // entry movement and handshake flags derived from the next occupancy
  always_comb begin
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          ent0_d = dec_s;
        end else begin
          ent0_d = ent0_q;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          ent0_d = dec_s;
        end else if (push_s) begin
          ent1_d = dec_s;
        end else begin
          ent0_d = ent0_q;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          ent0_d = ent1_q;
        end else begin
          ent0_d = ent0_q;
        end
      end
      default: begin
        ent0_d = ent0_q;
      end
    endcase
  end

  // datapath and handshake registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ent0_q      <= '0;
      ent1_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign alu_control   = ent0_q.alu_control;
  assign left_operand  = ent0_q.left;
  assign right_operand = ent0_q.right;
  assign rd            = ent0_q.rd;
  assign reg_write     = ent0_q.reg_write;
  assign illegal       = ent0_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode vectors, backpressure
// ordering, flush and reset behaviour.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, left_operand, right_operand;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
  logic        reg_write, illegal;
`ifdef FORWARD_EN
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = 5'd0;
  logic [31:0] fwd_data = 32'd0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef FORWARD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .left_operand(left_operand), .right_operand(right_operand), .rd(rd),
    .reg_write(reg_write), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, OPC_OP};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rdi);
    return {imm, rs1, f3, rdi, OPC_OP_IMM};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] p,
      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; instr = ins; pc = p; rs1_data = a; rs2_data = b;
  endtask

  // push one instruction with out_ready=1; leaves the entry at the head for checking
  task automatic send(input logic [31:0] ins, input logic [31:0] p,
      input logic [31:0] a, input logic [31:0] b);
    drive(ins, p, a, b);
    step();
    in_valid = 1'b0;
    check("send_out_valid", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic expect_head(input string tag, input logic [3:0] ctl, input logic [31:0] l,
      input logic [31:0] r, input logic [4:0] d, input logic w, input logic ill);
    check({tag, "_ctl"},  {60'd0, alu_control}, {60'd0, ctl});
    check({tag, "_left"}, {32'd0, left_operand}, {32'd0, l});
    check({tag, "_right"},{32'd0, right_operand}, {32'd0, r});
    check({tag, "_rd"},   {59'd0, rd}, {59'd0, d});
    check({tag, "_rw"},   {63'd0, reg_write}, {63'd0, w});
    check({tag, "_ill"},  {63'd0, illegal}, {63'd0, ill});
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    step(); step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    expect_head("rst", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();

    send(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7);
    expect_head("add", ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    step();
    check("drain_empty", {63'd0, out_valid}, 64'd0);

    send(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'h0, 32'd10, 32'd3);
    expect_head("sub", ALU_SUB, 32'd10, 32'd3, 5'd4, 1'b1, 1'b0);
    step();
    send(i_type(12'hFFF, 5'd1, 3'b000, 5'd5), 32'h0, 32'd20, 32'd99);
    expect_head("addi_m1", ALU_ADD, 32'd20, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
    step();
    send(i_type(12'h404, 5'd1, 3'b101, 5'd6), 32'h0, 32'h8000_0000, 32'd0);
    expect_head("srai", ALU_SRA, 32'h8000_0000, 32'd4, 5'd6, 1'b1, 1'b0);
    step();
    send(r_type(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd6), 32'h0, 32'h8000_0000, 32'h0000_0124);
    expect_head("sra", ALU_SRA, 32'h8000_0000, 32'd4, 5'd6, 1'b1, 1'b0);
    step();
    send(r_type(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd8), 32'h0, 32'd1, 32'd2);
    expect_head("sltu", ALU_SLTU, 32'd1, 32'd2, 5'd8, 1'b1, 1'b0);
    step();
    send(i_type(12'h0F0, 5'd1, 3'b111, 5'd9), 32'h0, 32'h1234, 32'd0);
    expect_head("andi", ALU_AND, 32'h1234, 32'h0000_00F0, 5'd9, 1'b1, 1'b0);
    step();
    send({20'h00002, 5'd10, OPC_AUIPC}, 32'h1000, 32'd77, 32'd88);
    expect_head("auipc", ALU_ADD, 32'h1000, 32'h2000, 5'd10, 1'b1, 1'b0);
    step();
    send({20'hABCDE, 5'd7, OPC_LUI}, 32'h40, 32'd1, 32'd1);
    expect_head("lui", ALU_ADD, 32'd0, 32'hABCD_E000, 5'd7, 1'b1, 1'b0);
    step();
    send({25'h1ABCDE5, 7'b1100011}, 32'h40, 32'd3, 32'd4);
    expect_head("illegal", ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    step();
    send(r_type(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd0), 32'h0, 32'd6, 32'd9);
    expect_head("or_x0", ALU_OR, 32'd6, 32'd9, 5'd0, 1'b0, 1'b0);
    step();

    // backpressure: three back-to-back pushes, only two fit
    out_ready = 1'b0;
    drive(i_type(12'd1, 5'd1, 3'b000, 5'd10), 32'h0, 32'd100, 32'd0);
    step();
    check("bp_ready_one", {63'd0, in_ready}, 64'd1);
    drive(i_type(12'd2, 5'd1, 3'b000, 5'd11), 32'h0, 32'd200, 32'd0);
    step();
    check("bp_ready_two", {63'd0, in_ready}, 64'd0);
    drive(i_type(12'd3, 5'd1, 3'b000, 5'd12), 32'h0, 32'd300, 32'd0);
    step();
    check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    expect_head("bp_a", ALU_ADD, 32'd100, 32'd1, 5'd10, 1'b1, 1'b0);
    out_ready = 1'b1;
    step();
    expect_head("bp_b", ALU_ADD, 32'd200, 32'd2, 5'd11, 1'b1, 1'b0);
    check("bp_ready_again", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    expect_head("bp_c", ALU_ADD, 32'd300, 32'd3, 5'd12, 1'b1, 1'b0);
    step();
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // flush with two buffered and a concurrent push
    out_ready = 1'b0;
    drive(i_type(12'd4, 5'd1, 3'b000, 5'd13), 32'h0, 32'd1, 32'd0);
    step();
    drive(i_type(12'd5, 5'd1, 3'b000, 5'd14), 32'h0, 32'd1, 32'd0);
    step();
    check("fl_full", {63'd0, in_ready}, 64'd0);
    drive(i_type(12'd6, 5'd1, 3'b000, 5'd15), 32'h0, 32'd1, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("fl_push_dropped", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    send(i_type(12'd7, 5'd1, 3'b100, 5'd16), 32'h0, 32'hF0, 32'd0);
    expect_head("post_flush", ALU_XOR, 32'hF0, 32'd7, 5'd16, 1'b1, 1'b0);
    step();

    // reset overrides flush mid-operation
    out_ready = 1'b0;
    drive(i_type(12'd8, 5'd1, 3'b000, 5'd17), 32'h0, 32'd1, 32'd0);
    step();
    drive(i_type(12'd9, 5'd1, 3'b000, 5'd18), 32'h0, 32'd1, 32'd0);
    reset_n = 1'b0; flush = 1'b1;
    step();
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    expect_head("mid_rst", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
